// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered results and a multi-cycle
// shift-add unsigned multiply, one operation in flight at a time.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alusel,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             cout,
    output logic             zero,
    output logic             illegal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] SEL_MUL     = 3'b101;
    localparam logic [2:0] SEL_ILLEGAL = 3'b111;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     addsum;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   res;
    logic               res_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // acc holds {partial product, remaining multiplier}; bit 0 selects the add
    always_comb begin
        addsum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {addsum, acc[WIDTH-1:1]};
    end

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (alusel)
            3'b000: res = ~a;
            3'b010: res = a & b;
            3'b100: res = a | b;
            3'b110: res = a ^ b;
            3'b001: {res_c, res} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
            3'b011: {res_c, res} = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
            default: begin
                res   = '0;
                res_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            acc     <= '0;
            y       <= '0;
            y_hi    <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (alusel == SEL_MUL) begin
                            mcand <= a;
                            acc   <= {{WIDTH{1'b0}}, b};
                            count <= '0;
                            state <= MUL;
                        end else begin
                            y       <= res;
                            y_hi    <= '0;
                            cout    <= res_c;
                            zero    <= (res == '0);
                            illegal <= (alusel == SEL_ILLEGAL);
                            state   <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    if (count == LAST) begin
                        y       <= acc_next[WIDTH-1:0];
                        y_hi    <= acc_next[2*WIDTH-1:WIDTH];
                        cout    <= 1'b0;
                        zero    <= (acc_next == '0);
                        illegal <= 1'b0;
                        state   <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 4-bit and an 8-bit instance share the clock,
// reset and operand buses; a negedge monitor pops expected results per instance.
module tb_seq_alu;

    typedef struct {
        logic [7:0] y;
        logic [7:0] y_hi;
        logic       cout;
        logic       zero;
        logic       illegal;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv4 = 1'b0;
    logic       iv8 = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic [2:0] op_sel = '0;
    logic       op_cin = 1'b0;

    logic       in_ready4, out_valid4, cout4, zero4, illegal4;
    logic [3:0] y4, y_hi4;
    logic       in_ready8, out_valid8, cout8, zero8, illegal8;
    logic [7:0] y8, y_hi8;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(in_ready4),
        .a(op_a[3:0]), .b(op_b[3:0]), .alusel(op_sel), .cin(op_cin),
        .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .y_hi(y_hi4),
        .cout(cout4), .zero(zero4), .illegal(illegal4)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8),
        .a(op_a), .b(op_b), .alusel(op_sel), .cin(op_cin),
        .out_valid(out_valid8), .out_ready(out_ready), .y(y8), .y_hi(y_hi8),
        .cout(cout8), .zero(zero8), .illegal(illegal8)
    );

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Results are consumed on the edge after a negedge that sees valid && ready
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    checkOutput("u8 unexpected out_valid", 32'(out_valid8), 32'd0);
                end else begin
                    e = q8.pop_front();
                    checkOutput({"u8 ", e.name}, 32'({y_hi8, y8, cout8, zero8, illegal8}),
                                32'({e.y_hi, e.y, e.cout, e.zero, e.illegal}));
                end
            end
            if (out_valid4) begin
                if (q4.size() == 0) begin
                    checkOutput("u4 unexpected out_valid", 32'(out_valid4), 32'd0);
                end else begin
                    e = q4.pop_front();
                    checkOutput({"u4 ", e.name}, 32'({4'h0, y_hi4, 4'h0, y4, cout4, zero4, illegal4}),
                                32'({e.y_hi, e.y, e.cout, e.zero, e.illegal}));
                end
            end
        end
    end

    task automatic applyStimulus(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [2:0] s, input logic c, input bit push,
                                 input logic [7:0] ey, input logic [7:0] eyh, input logic ec,
                                 input logic ez, input logic eil, input string nm, input int exp_lat);
        exp_t x;
        int   guard;
        int   lat;
        logic ready_seen;
        guard = 0;
        while (!(w8 ? in_ready8 : in_ready4) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) checkOutput({nm, " in_ready timeout"}, 32'(w8 ? in_ready8 : in_ready4), 32'd1);
        op_a = av; op_b = bv; op_sel = s; op_cin = c;
        iv8 = w8; iv4 = !w8;
        if (push) begin
            x.y = ey; x.y_hi = eyh; x.cout = ec; x.zero = ez; x.illegal = eil; x.name = nm;
            if (w8) q8.push_back(x); else q4.push_back(x);
        end
        @(posedge clk); #1;
        iv8 = 1'b0; iv4 = 1'b0;
        op_a = ~av; op_b = ~bv; op_cin = ~c;
        lat = 1;
        ready_seen = 1'b0;
        while (!(w8 ? out_valid8 : out_valid4) && lat < 100) begin
            if (w8 ? in_ready8 : in_ready4) ready_seen = 1'b1;
            op_sel = 3'b001;
            iv8 = w8; iv4 = !w8;
            @(posedge clk); #1;
            lat++;
        end
        iv8 = 1'b0; iv4 = 1'b0;
        op_sel = s;
        checkOutput({nm, " latency"}, 32'(lat), 32'(exp_lat));
        if (s == 3'b101) checkOutput({nm, " in_ready during MUL"}, 32'(ready_seen), 32'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q4.size() != 0 || q8.size() != 0) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("result drain", 32'(q4.size() + q8.size()), 32'd0);
    endtask

    task automatic runOp(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] s, input logic c,
                         input logic [7:0] ey, input logic [7:0] eyh, input logic ec,
                         input logic ez, input logic eil, input string nm, input int exp_lat);
        applyStimulus(w8, av, bv, s, c, 1'b1, ey, eyh, ec, ez, eil, nm, exp_lat);
        drain();
    endtask

    initial begin
        int busy;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset u8 outputs", 32'({in_ready8, out_valid8, y8, y_hi8, cout8, zero8, illegal8}),
                    32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}));
        checkOutput("reset u4 outputs", 32'({in_ready4, out_valid4, y4, y_hi4, cout4, zero4, illegal4}),
                    32'({1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        runOp(1'b0, 8'h0F, 8'h01, 3'b001, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "add F+1", 1);
        runOp(1'b0, 8'h03, 8'h05, 3'b011, 1'b1, 8'h0D, 8'h00, 1'b1, 1'b0, 1'b0, "sub 3-5-1", 1);
        runOp(1'b0, 8'h09, 8'h04, 3'b011, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, "sub 9-4", 1);
        runOp(1'b0, 8'h05, 8'h06, 3'b001, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0, "add 5+6+1", 1);

        runOp(1'b1, 8'hFF, 8'hFF, 3'b101, 1'b1, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, "mul FF*FF", 9);
        runOp(1'b1, 8'h0D, 8'h0B, 3'b101, 1'b0, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, "mul 0D*0B", 9);
        runOp(1'b1, 8'h00, 8'h05, 3'b101, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "mul 0*5", 9);

        runOp(1'b1, 8'hA5, 8'h3C, 3'b000, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, "not", 1);
        runOp(1'b1, 8'hA5, 8'h3C, 3'b010, 1'b1, 8'h24, 8'h00, 1'b0, 1'b0, 1'b0, "and", 1);
        runOp(1'b1, 8'hA5, 8'h3C, 3'b100, 1'b1, 8'hBD, 8'h00, 1'b0, 1'b0, 1'b0, "or", 1);
        runOp(1'b1, 8'hA5, 8'h3C, 3'b110, 1'b1, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, "xor", 1);
        runOp(1'b1, 8'hA5, 8'h3C, 3'b111, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "illegal", 1);
        runOp(1'b1, 8'h00, 8'h00, 3'b011, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, "sub 0-0-1", 1);

        // Backpressure: result must hold while the sink stalls
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'h40, 8'h02, 3'b001, 1'b0, 1'b1, 8'h42, 8'h00, 1'b0, 1'b0, 1'b0, "add stalled", 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall hold", 32'({out_valid8, in_ready8, y8}), 32'({1'b1, 1'b0, 8'h42}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall release", 32'({in_ready8, out_valid8}), 32'({1'b1, 1'b0}));
        checkOutput("stall single transfer", 32'(q8.size()), 32'd0);

        // Abort a multiply with an asynchronous reset after three steps
        op_a = 8'h12; op_b = 8'h34; op_sel = 3'b101; op_cin = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async reset u8", 32'({in_ready8, out_valid8, y8, y_hi8, cout8, zero8, illegal8}),
                    32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid8) busy++;
            @(posedge clk); #1;
        end
        checkOutput("no result after abort", 32'(busy), 32'd0);
        runOp(1'b1, 8'h01, 8'h01, 3'b001, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, "add 1+1 after reset", 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It keeps the same `alusel = {S1,S0,M}` operation encoding and adds three things:
- configurable operand width;
- registered results on a valid/ready interface;
- a multi-cycle unsigned shift-add multiply mode.

It sits between an operand source (register file or test sequencer) and a result sink, one operation in flight at a time.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; must be ≥ 2.

Ports:
- `clk`  input  1  sole clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  operand bundle valid.
- `in_ready`  output  1  block can accept an operation.
- `a`, `b`  input  WIDTH each  operands, unsigned.
- `alusel`  input  3  operation select `{S1,S0,M}`.
- `cin`  input  1  carry-in (ADD) or borrow-in (SUB).
- `out_valid`  output  1  result bundle valid.
- `out_ready`  input  1  sink accepts result.
- `y`  output  WIDTH  result (low half for MUL).
- `y_hi`  output  WIDTH  high half of MUL product; 0 for other ops.
- `cout`  output  1  carry / borrow; 0 for logic ops and MUL.
- `zero`  output  1  1 when `{y_hi,y}` is all zero.
- `illegal`  output  1  1 when the accepted `alusel` is unused (111).

## Operation
Encodings (`alusel` value: result, `cout`):
- 000: `y = ~a`; `cout = 0`.
- 010: `a & b`; `cout = 0`.
- 100: `a | b`; `cout = 0`.
- 110: `a ^ b`; `cout = 0`.
- 001: `{cout,y} = a + b + cin`, computed in WIDTH+1 bits.
- 011: `{cout,y} = {0,a} - {0,b} - cin`, WIDTH+1 bits; `cout = 1` iff `a < b + cin` (borrow).
- 101: MUL, `{y_hi,y} = a * b`, unsigned, 2·WIDTH bits; `cin` is ignored.
- 111: `y = y_hi = 0`, `cout = 0`, `illegal = 1`.

Operand capture:
- The handshake `in_valid && in_ready` at a rising edge captures `a`, `b`, `alusel` and `cin` into internal registers.
- Later changes on those inputs have no effect on the operation in flight.

FSM states IDLE, MUL, DONE:
- IDLE: `in_ready = 1`. On accept, a non-MUL op computes its result into the output registers and goes to DONE. MUL loads the multiplicand, multiplier and a cleared accumulator, sets `count = 0`, and goes to MUL.
- MUL: performs one shift-add step per cycle. If multiplier bit 0 is 1, add the multiplicand to the accumulator upper half. Then shift `{carry,acc}` right by 1. After WIDTH steps (`count == WIDTH-1`), write the product to `y_hi`/`y` and go to DONE.
- DONE: `out_valid = 1`. All outputs are held stable until `out_ready`. The `out_valid && out_ready` handshake at an edge returns to IDLE.

Rules:
- `in_ready` is high only in IDLE; there is no overlap of accept and output.
- `zero`, `illegal` and `cout` are registered together with `y` and are valid only while `out_valid = 1`.

## Timing
- Reset (asynchronous, `rst_n = 0`) forces IDLE. Reset values: `in_ready = 1`, `out_valid = 0`, `y = 0`, `y_hi = 0`, `cout = 0`, `zero = 0`, `illegal = 0`, `count = 0`.
- Reset asserted mid-MUL or in DONE abandons the operation. No result is produced after release.
- Latency from the accept edge to `out_valid` high:
  - 1 cycle for logic, ADD, SUB and 111;
  - WIDTH+1 cycles for MUL (WIDTH step cycles, then DONE).
- With `out_ready` held high, a result is consumed in its first DONE cycle. Next accept can happen one cycle later. Peak throughput is one non-MUL op per 2 cycles and one MUL per WIDTH+2 cycles.
- `out_ready` is sampled only in DONE and ignored elsewhere. `in_valid` is ignored outside IDLE.
- Wrap-around: ADD/SUB results are modulo 2^WIDTH, with overflow or borrow reported only in `cout`. For MUL, `count` never exceeds WIDTH-1.

## Test plan
- WIDTH = 4, reset then ADD `a = 4'hF`, `b = 4'h1`, `cin = 0` → one cycle later `out_valid = 1`, `y = 0`, `cout = 1`, `zero = 1`.
- WIDTH = 4, SUB `a = 3`, `b = 5`, `cin = 1` → `y = 4'hD`, `cout = 1`. Then SUB `a = 9`, `b = 4`, `cin = 0` → `y = 5`, `cout = 0`.
- WIDTH = 8, MUL `a = 8'hFF`, `b = 8'hFF` → `out_valid` rises exactly 9 cycles after accept, with `y_hi = 8'hFE` and `y = 8'h01`. `in_ready = 0` throughout; `in_valid` pulses during MUL are ignored.
- WIDTH = 8, ops 000, 010, 100, 110 on `a = 8'hA5`, `b = 8'h3C` → `y = 5A`, `24`, `BD`, `99` respectively, each with `cout = 0` and `zero = 0`. `alusel = 111` → `y = 0`, `illegal = 1`, `zero = 1`.
- Backpressure: hold `out_ready = 0` for 5 cycles after a result → `out_valid` and `y` stay stable and `in_ready = 0`. Raising `out_ready` gives 1 transfer, and `in_ready` returns high the next cycle.
- Assert `rst_n = 0` at MUL step 3 of 8 → outputs go to reset values immediately (asynchronous). After release no `out_valid` appears, and a following ADD `1 + 1` yields `y = 2`.
